// File: rtl/cpu_pkg.sv
// cpu_pkg: fetch-stage state encoding, decoder field positions and reset defaults
package cpu_pkg;
    localparam logic [1:0] FS_IDLE  = 2'd0;
    localparam logic [1:0] FS_WAIT  = 2'd1;
    localparam logic [1:0] FS_DRAIN = 2'd2;
    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: 2-entry in-order queue of pc/word pairs; entry 0 is the out register, entry 1 the skid
module fetch_skid import cpu_pkg::*; #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic [31:0]       push_word,
    input  logic              pop,
    input  logic              flush,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_pc,
    output logic [31:0]       out_word,
    output logic              full_next
);
    logic              ov_q, ov_d, sv_q, sv_d;
    logic [ADDR_W-1:0] opc_q, opc_d, spc_q, spc_d;
    logic [31:0]       ow_q, ow_d, sw_q, sw_d;

    // pop shifts the skid forward first, so a same-edge push lands behind it
    always_comb begin
        ov_d  = pop ? sv_q : ov_q;
        opc_d = (pop && sv_q) ? spc_q : opc_q;
        ow_d  = (pop && sv_q) ? sw_q : ow_q;
        sv_d  = pop ? 1'b0 : sv_q;
        spc_d = spc_q;
        sw_d  = sw_q;
        if (push && !ov_d) begin
            ov_d  = 1'b1;
            opc_d = push_pc;
            ow_d  = push_word;
        end else if (push) begin
            sv_d  = 1'b1;
            spc_d = push_pc;
            sw_d  = push_word;
        end
        if (flush) begin
            ov_d = 1'b0;
            sv_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ov_q  <= 1'b0;
            sv_q  <= 1'b0;
            opc_q <= '0;
            spc_q <= '0;
            ow_q  <= '0;
            sw_q  <= '0;
        end else begin
            ov_q  <= ov_d;
            sv_q  <= sv_d;
            opc_q <= opc_d;
            spc_q <= spc_d;
            ow_q  <= ow_d;
            sw_q  <= sw_d;
        end
    end

    assign out_valid = ov_q;
    assign out_pc    = opc_q;
    assign out_word  = ow_q;
    assign full_next = sv_d;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC owner issuing single-outstanding imem requests into a 2-entry output queue
module instr_fetch import cpu_pkg::*; #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter int                PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              stall,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [31:0]       instr,
    output logic [5:0]        op,
    output logic [5:0]        funct
);
    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d;
    logic              req_q, req_d;
    logic              pop, push, issue, skid_full_d;

    assign pop   = if_valid && !stall && !redirect;
    assign push  = state_q == FS_WAIT && imem_ack && !redirect;
    // issuing only into an empty skid keeps any ack from finding both entries full
    assign issue = !redirect && !skid_full_d &&
                   (state_q == FS_IDLE || (state_q == FS_WAIT && imem_ack));

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        pc_d    = redirect ? redirect_pc : issue ? pc_q + ADDR_W'(PC_STEP) : pc_q;
        if (issue) begin
            state_d = FS_WAIT;
            req_d   = 1'b1;
            addr_d  = pc_q;
        end else if (state_q == FS_WAIT && redirect && !imem_ack) begin
            state_d = FS_DRAIN;
        end else if (state_q != FS_IDLE && imem_ack) begin
            state_d = FS_IDLE;
            req_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FS_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
        end
    end

    fetch_skid #(.ADDR_W(ADDR_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_pc   (addr_q),
        .push_word (imem_rdata),
        .pop       (pop),
        .flush     (redirect),
        .out_valid (if_valid),
        .out_pc    (if_pc),
        .out_word  (instr),
        .full_next (skid_full_d)
    );

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign op        = instr[OP_MSB:OP_LSB];
    assign funct     = instr[FUNCT_MSB:FUNCT_LSB];
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed vectors against a latency-configurable addr-as-data memory
module tb_instr_fetch;
    logic        clk = 1'b0, rst = 1'b1;
    logic        imem_req, imem_ack, redirect = 1'b0, stall = 1'b0, if_valid;
    logic [31:0] imem_addr, imem_rdata, redirect_pc = '0, if_pc, instr;
    logic [5:0]  op, funct;
    logic        req2, ack2, valid2;
    logic [31:0] addr2, pc2, instr2;
    logic [5:0]  op2, funct2;
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_data = '0;
    int          lat = 0, cnt = 0, n_cmp = 0, n_bad = 0;

    typedef struct {
        logic        stall;
        logic        valid;
        logic [31:0] pc;
        logic        req;
        logic [31:0] addr;
    } vec_t;
    vec_t vec [12];

    always #5 clk = ~clk;

    // memory acks once a request has been up for lat+1 cycles; data is the address unless overridden
    always @(posedge clk or posedge rst)
        if (rst) cnt <= 0;
        else cnt <= (imem_req && !imem_ack) ? cnt + 1 : 0;
    assign imem_ack   = imem_req && cnt == lat;
    assign imem_rdata = ovr_en ? ovr_data : imem_addr;
    assign ack2       = req2;

    instr_fetch dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
        .if_valid(if_valid), .if_pc(if_pc), .instr(instr), .op(op), .funct(funct)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2),
        .imem_rdata(addr2), .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
        .if_valid(valid2), .if_pc(pc2), .instr(instr2), .op(op2), .funct(funct2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        redirect = 1'b0;
        stall = 1'b0;
        ovr_en = 1'b0;
        #1;
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_valid", if_valid, 0);
        check("rst_pc", if_pc, 0);
        check("rst_instr", instr, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vec[0]  = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd0};
        vec[1]  = '{1'b1, 1'b1, 32'd0,  1'b1, 32'd4};
        vec[2]  = '{1'b1, 1'b1, 32'd0,  1'b0, 32'd4};
        vec[3]  = '{1'b1, 1'b1, 32'd0,  1'b0, 32'd4};
        vec[4]  = '{1'b1, 1'b1, 32'd0,  1'b0, 32'd4};
        vec[5]  = '{1'b1, 1'b1, 32'd0,  1'b0, 32'd4};
        vec[6]  = '{1'b0, 1'b1, 32'd4,  1'b1, 32'd8};
        vec[7]  = '{1'b0, 1'b1, 32'd8,  1'b1, 32'd12};
        vec[8]  = '{1'b0, 1'b1, 32'd12, 1'b1, 32'd16};
        vec[9]  = '{1'b1, 1'b1, 32'd12, 1'b0, 32'd16};
        vec[10] = '{1'b0, 1'b1, 32'd16, 1'b1, 32'd20};
        vec[11] = '{1'b0, 1'b1, 32'd20, 1'b1, 32'd24};

        // zero-wait memory with stall windows; wrap instance checked on its first two fetches
        lat = 0;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            stall = vec[i].stall;
            step();
            check($sformatf("v%0d_valid", i), if_valid, vec[i].valid);
            check($sformatf("v%0d_pc", i), if_pc, vec[i].pc);
            check($sformatf("v%0d_instr", i), instr, vec[i].pc);
            check($sformatf("v%0d_req", i), imem_req, vec[i].req);
            check($sformatf("v%0d_addr", i), imem_addr, vec[i].addr);
            if (i == 0) check("wrap_addr0", addr2, 32'hFFFF_FFFC);
            if (i == 1) check("wrap_addr1", addr2, 32'h0000_0000);
        end

        // 3-cycle memory: each address held three cycles, one valid pulse per word
        lat = 2;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            step();
            check($sformatf("slow%0d_addr", k), imem_addr, 32'(4 * (k / 3)));
            check($sformatf("slow%0d_valid", k), if_valid, (k >= 3 && k % 3 == 0) ? 1 : 0);
            if (k >= 3 && k % 3 == 0) check($sformatf("slow%0d_pc", k), if_pc, 32'(4 * (k / 3 - 1)));
        end

        // redirect while a request is outstanding: stale word must be discarded
        lat = 2;
        do_reset();
        step();
        check("rd_e1_addr", imem_addr, 0);
        redirect = 1'b1;
        redirect_pc = 32'h100;
        ovr_en = 1'b1;
        ovr_data = 32'hDEAD_BEEF;
        step();
        redirect = 1'b0;
        check("rd_e2_req", imem_req, 1);
        check("rd_e2_addr", imem_addr, 0);
        step();
        check("rd_e3_req", imem_req, 1);
        step();
        check("rd_e4_req", imem_req, 0);
        check("rd_e4_valid", if_valid, 0);
        check("rd_e4_stale", instr == 32'hDEAD_BEEF, 0);
        ovr_en = 1'b0;
        step();
        check("rd_e5_req", imem_req, 1);
        check("rd_e5_addr", imem_addr, 32'h100);
        step();
        step();
        check("rd_e7_valid", if_valid, 0);
        step();
        check("rd_e8_valid", if_valid, 1);
        check("rd_e8_pc", if_pc, 32'h100);
        check("rd_e8_instr", instr, 32'h100);

        // redirect with skid full under stall
        lat = 0;
        do_reset();
        stall = 1'b1;
        step();
        step();
        step();
        check("sk_full_req", imem_req, 0);
        check("sk_full_valid", if_valid, 1);
        redirect = 1'b1;
        redirect_pc = 32'h200;
        step();
        check("sk_rd_valid", if_valid, 0);
        check("sk_rd_req", imem_req, 0);
        redirect = 1'b0;
        stall = 1'b0;
        step();
        check("sk_e5_req", imem_req, 1);
        check("sk_e5_addr", imem_addr, 32'h200);
        step();
        check("sk_e6_valid", if_valid, 1);
        check("sk_e6_pc", if_pc, 32'h200);
        step();
        check("sk_e7_pc", if_pc, 32'h204);

        // op/funct slicing
        lat = 0;
        do_reset();
        stall = 1'b1;
        ovr_en = 1'b1;
        ovr_data = 32'h0000_0020;
        step();
        step();
        check("of_instr", instr, 32'h20);
        check("of_op0", op, 0);
        check("of_funct0", funct, 6'h20);
        ovr_data = 32'hFC00_0015;
        step();
        stall = 1'b0;
        step();
        check("of_op1", op, 6'h3F);
        check("of_funct1", funct, 6'h15);
        ovr_en = 1'b0;

        // asynchronous reset while a request is up
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the registered op/funct control decoder.
- Owns the PC and issues single-outstanding requests to instruction memory.
- Buffers returned words in a 2-entry output queue: out register plus skid.
- Presents op/funct slices to the decoder. Accepts branch/jump redirects from downstream and flushes in-flight work on each redirect.

Parameters:
ADDR_W, 32, width of PC and instruction-memory address
RESET_PC, 32'h0000_0000, first fetch address after reset
PC_STEP, 4, byte increment between sequential fetches

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
imem_req  out  1  request valid (registered)
imem_addr  out  ADDR_W  request address (registered), stable while imem_req=1
imem_ack  in  1  memory completes the request at this edge; meaningful only when imem_req=1
imem_rdata  in  32  instruction word, valid with imem_ack
redirect  in  1  branch/jump taken; flush fetch
redirect_pc  in  ADDR_W  target address, valid with redirect
stall  in  1  decoder cannot accept this cycle
if_valid  out  1  out register holds a valid instruction
if_pc  out  ADDR_W  address of the instruction in out register
instr  out  32  instruction word in out register
op  out  6  instr[31:26], combinational slice, to decoder op
funct  out  6  instr[5:0], combinational slice, to decoder funct

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous, active-high.
- Reset values:
  - pc=RESET_PC, state=IDLE
  - imem_req=0, imem_addr=0
  - if_valid=0, skid_valid=0, if_pc=0, instr=0
- Consume: occurs at an edge where if_valid=1 and stall=0 and redirect=0.
  - At that edge, the out register takes the skid entry if present, else the returning word (ack), else becomes invalid.
- Issue: imem_addr<=pc, pc<=pc+PC_STEP (mod 2^ADDR_W), imem_req<=1.
  - Allowed only when the skid will be empty after this edge.
  - Guarantees no ack ever finds both entries full.
- States:
  - IDLE: no outstanding request. Issue if allowed → WAIT.
  - WAIT: request outstanding, imem_req=1, address held.
    - On ack: push imem_rdata/imem_addr into out (if empty or consumed this edge) else into skid.
    - Then issue again same edge if allowed (stay WAIT, imem_req stays 1), else imem_req<=0 → IDLE.
    - No ack: hold.
  - DRAIN: stale request outstanding, imem_req=1, address held.
    - On ack: discard data, imem_req<=0 → IDLE.
- Redirect (priority over stall and ack-push):
  - pc<=redirect_pc; if_valid<=0, skid_valid<=0.
  - In WAIT without ack → DRAIN.
  - In WAIT with ack → data dropped, → IDLE.
  - In IDLE → IDLE; the new fetch issues next cycle.
  - In DRAIN → stay DRAIN, pc updated to newest target.
- Throughput and latency:
  - With zero-wait memory (ack in first req cycle): one instruction per cycle sustained.
  - First if_valid two edges after rst deasserts.
- Stall:
  - Holds the out register.
  - At most one more word is absorbed in skid; then requests stop until a consume.
- Order: instructions always leave in issue order. Skid entry never bypasses out.
- Reset mid-request: state cleared immediately; any later ack while imem_req=0 is ignored.
- PC wrap: all-ones region + PC_STEP wraps to 0 silently.

Decomposition:
- Shared package (cpu_pkg):
  - fetch state encoding {IDLE, WAIT, DRAIN}
  - OP_FIELD/FUNCT_FIELD bit positions
  - RESET_PC default
- One natural sub-module: fetch_skid (2-entry in-order queue, push/pop/flush, full/empty), holding pc+word pairs.

Test Plan:
- Reset then zero-wait memory returning addr-as-data, stall=0 → imem_addr 0,4,8,… on consecutive cycles; if_valid first high 2 edges after reset release; if_pc/instr track 0,4,8 one per cycle.
- Memory with 3-cycle ack latency → imem_addr held stable 3 cycles; if_valid pulses once per 3 cycles; no duplicated or skipped pc.
- stall=1 for 5 cycles with zero-wait memory → out holds pc 0, skid fills with pc 4, imem_req drops; on release, pc 4 then 8 issue in order, no loss.
- redirect to 0x100 while WAIT outstanding (ack 2 cycles later with word 0xDEADBEEF) → state DRAIN; 0xDEADBEEF never appears on instr; next imem_addr=0x100; if_pc=0x100.
- redirect with skid full and stall=1 → if_valid and skid cleared at that edge; next fetch from redirect_pc.
- instr=0x00000020 on out → op=0, funct=0x20; RESET_PC=0xFFFF_FFFC → second fetch address 0x0000_0000.
